// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port data RAM between instruction fetch (port 0)
//            and load/store (port 1); one access per cycle, registered read
//            data, saturating contention counter.
// Options  : MEM_ARB_RR_EN defined -> round-robin, undefined -> port 1 priority
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  i_p0_req,
    input  logic                  i_p0_we,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [DATA_WIDTH-1:0] i_p0_wdata,
    output logic                  o_p0_gnt,
    output logic                  o_p0_rvalid,
    output logic [DATA_WIDTH-1:0] o_p0_rdata,

    input  logic                  i_p1_req,
    input  logic                  i_p1_we,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [DATA_WIDTH-1:0] i_p1_wdata,
    output logic                  o_p1_gnt,
    output logic                  o_p1_rvalid,
    output logic [DATA_WIDTH-1:0] o_p1_rdata,

    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_we,
    input  logic [DATA_WIDTH-1:0] i_ram_data,

    output logic [CNT_WIDTH-1:0]  o_conflicts
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_both;
    logic                  r_p0_rvalid;
    logic                  r_p1_rvalid;
    logic [DATA_WIDTH-1:0] r_p0_rdata;
    logic [DATA_WIDTH-1:0] r_p1_rdata;
    logic [CNT_WIDTH-1:0]  r_conflicts;

    assign w_both = i_p0_req & i_p1_req;

`ifdef MEM_ARB_RR_EN
    // 1 = port 1 won the most recent grant, so port 0 wins the next contention
    logic r_last;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_rst) begin
            w_gnt0 = i_p0_req & (~i_p1_req | r_last);
            w_gnt1 = i_p1_req & (~i_p0_req | ~r_last);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (w_gnt0 | w_gnt1) begin
            r_last <= w_gnt1;
        end
    end
`else
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_rst) begin
            w_gnt1 = i_p1_req;
            w_gnt0 = i_p0_req & ~i_p1_req;
        end
    end
`endif

    // RAM lines are forced to zero whenever nobody is granted
    always_comb begin
        o_ram_addr = '0;
        o_ram_data = '0;
        o_ram_we   = 1'b0;
        if (w_gnt1) begin
            o_ram_addr = i_p1_addr;
            o_ram_data = i_p1_wdata;
            o_ram_we   = i_p1_we;
        end else if (w_gnt0) begin
            o_ram_addr = i_p0_addr;
            o_ram_data = i_p0_wdata;
            o_ram_we   = i_p0_we;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            r_p0_rvalid <= w_gnt0 & ~i_p0_we;
            r_p1_rvalid <= w_gnt1 & ~i_p1_we;
            if (w_gnt0 && !i_p0_we) begin
                r_p0_rdata <= i_ram_data;
            end
            if (w_gnt1 && !i_p1_we) begin
                r_p1_rdata <= i_ram_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_conflicts <= '0;
        end else if (w_both && (r_conflicts != C_CNT_MAX)) begin
            r_conflicts <= r_conflicts + 1'b1;
        end
    end

    assign o_p0_gnt    = w_gnt0;
    assign o_p1_gnt    = w_gnt1;
    assign o_p0_rvalid = r_p0_rvalid;
    assign o_p1_rvalid = r_p1_rvalid;
    assign o_p0_rdata  = r_p0_rdata;
    assign o_p1_rdata  = r_p1_rdata;
    assign o_conflicts = r_conflicts;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a RAM model, a grant
//            model and per-port read-data scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [5:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_we;
    logic [15:0] conflicts;

    logic        c2_p0_gnt, c2_p1_gnt, c2_p0_rvalid, c2_p1_rvalid, c2_ram_we;
    logic [31:0] c2_p0_rdata, c2_p1_rdata, c2_ram_wdata;
    logic [31:0] c2_ram_rdata;
    logic [5:0]  c2_ram_addr;
    logic [1:0]  c2_conflicts;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .i_clk(clk), .i_rst(rst),
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
        .o_p0_gnt(p0_gnt), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
        .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata),
        .o_ram_addr(ram_addr), .o_ram_data(ram_wdata), .o_ram_we(ram_we),
        .i_ram_data(ram_rdata), .o_conflicts(conflicts)
    );

    // Narrow-counter instance sharing the request inputs, for saturation
    mem_arbiter #(.CNT_WIDTH(2)) dut_c2 (
        .i_clk(clk), .i_rst(rst),
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
        .o_p0_gnt(c2_p0_gnt), .o_p0_rvalid(c2_p0_rvalid), .o_p0_rdata(c2_p0_rdata),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
        .o_p1_gnt(c2_p1_gnt), .o_p1_rvalid(c2_p1_rvalid), .o_p1_rdata(c2_p1_rdata),
        .o_ram_addr(c2_ram_addr), .o_ram_data(c2_ram_wdata), .o_ram_we(c2_ram_we),
        .i_ram_data(c2_ram_rdata), .o_conflicts(c2_conflicts)
    );

    assign c2_ram_rdata = 32'h0;

    // RAM model: combinational read, write at rising edge
    logic [31:0] ram [0:63];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = ram[ram_addr];

    // Reference model state
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] gold [0:63];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    bit          m_rv0 = 1'b0, m_rv1 = 1'b0;
    logic [31:0] m_rd0 = 32'h0, m_rd1 = 32'h0;
    logic [15:0] m_cnt  = 16'h0;
    logic [1:0]  m_cnt2 = 2'h0;
`ifdef MEM_ARB_RR_EN
    bit          m_ptr  = 1'b1;
`endif
    bit          e_g0, e_g1;
    bit          obs_g1;
    logic [3:0]  gseq;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: compare at the falling edge, advance the model, then clock
    task automatic step();
        logic [5:0]  ea;
        logic [31:0] ed;
        logic        ew;
        @(negedge clk);
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (!rst) begin
`ifdef MEM_ARB_RR_EN
            e_g0 = p0_req && (!p1_req || m_ptr);
            e_g1 = p1_req && (!p0_req || !m_ptr);
`else
            e_g1 = p1_req;
            e_g0 = p0_req && !p1_req;
`endif
        end
        ea = e_g1 ? p1_addr  : (e_g0 ? p0_addr  : 6'h0);
        ed = e_g1 ? p1_wdata : (e_g0 ? p0_wdata : 32'h0);
        ew = e_g1 ? p1_we    : (e_g0 ? p0_we    : 1'b0);
        obs_g1 = p1_gnt;
        check("p0_gnt", 64'(p0_gnt), 64'(e_g0));
        check("p1_gnt", 64'(p1_gnt), 64'(e_g1));
        check("ram_we", 64'(ram_we), 64'(ew));
        check("ram_addr", 64'(ram_addr), 64'(ea));
        check("ram_data", 64'(ram_wdata), 64'(ed));
        check("p0_rvalid", 64'(p0_rvalid), 64'(m_rv0));
        check("p1_rvalid", 64'(p1_rvalid), 64'(m_rv1));
        if (m_rv0 && q0.size() > 0) m_rd0 = q0.pop_front();
        if (m_rv1 && q1.size() > 0) m_rd1 = q1.pop_front();
        check("p0_rdata", 64'(p0_rdata), 64'(m_rd0));
        check("p1_rdata", 64'(p1_rdata), 64'(m_rd1));
        check("conflicts", 64'(conflicts), 64'(m_cnt));
        check("conflicts_w2", 64'(c2_conflicts), 64'(m_cnt2));

        m_rv0 = e_g0 && !p0_we;
        m_rv1 = e_g1 && !p1_we;
        if (m_rv0) q0.push_back(gold[p0_addr]);
        if (m_rv1) q1.push_back(gold[p1_addr]);
        if (e_g0 && p0_we) gold[p0_addr] = p0_wdata;
        if (e_g1 && p1_we) gold[p1_addr] = p1_wdata;
        if (rst) begin
            m_rd0  = 32'h0;
            m_rd1  = 32'h0;
            m_cnt  = 16'h0;
            m_cnt2 = 2'h0;
`ifdef MEM_ARB_RR_EN
            m_ptr  = 1'b1;
`endif
        end else begin
            if (p0_req && p1_req) begin
                if (m_cnt != 16'hFFFF) m_cnt++;
                if (m_cnt2 != 2'h3) m_cnt2++;
            end
`ifdef MEM_ARB_RR_EN
            if (e_g0 || e_g1) m_ptr = e_g1;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [5:0] a, input logic [31:0] d);
        p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [5:0] a, input logic [31:0] d);
        p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
    endtask

    initial begin
        rst = 1'b1;
        set_p0(1'b1, 1'b0, 6'd1, 32'h0);
        set_p1(1'b1, 1'b0, 6'd2, 32'h0);
        @(posedge clk);
        #1;
        // Reset held with both requests high
        step();
        step();
        rst = 1'b0;
        set_p0(1'b0, 1'b0, 6'd0, 32'h0);
        set_p1(1'b0, 1'b0, 6'd0, 32'h0);
        step();

        // Load 0xDEADBEEF at 5, then port 0 reads it
        set_p1(1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
        step();
        set_p1(1'b0, 1'b0, 6'd0, 32'h0);
        set_p0(1'b1, 1'b0, 6'd5, 32'h0);
        step();
        set_p0(1'b0, 1'b0, 6'd0, 32'h0);
        step();
        check("p0_rdata_deadbeef", 64'(p0_rdata), 64'h0000_0000_DEAD_BEEF);

        // Port 1 write then port 0 read of the same word
        set_p1(1'b1, 1'b1, 6'd9, 32'h12345678);
        step();
        set_p1(1'b0, 1'b0, 6'd0, 32'h0);
        set_p0(1'b1, 1'b0, 6'd9, 32'h0);
        step();
        set_p0(1'b0, 1'b0, 6'd0, 32'h0);
        step();
        check("p0_rdata_12345678", 64'(p0_rdata), 64'h0000_0000_1234_5678);

        // Port 1 read leaves the pointer on port 1 before contention
        set_p1(1'b1, 1'b0, 6'd9, 32'h0);
        step();
        set_p0(1'b1, 1'b0, 6'd5, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            gseq[i] = obs_g1;
        end
`ifdef MEM_ARB_RR_EN
        check("contention_order", 64'(gseq), 64'(4'b1010));
`else
        check("contention_order", 64'(gseq), 64'(4'b1111));
`endif
        step();
        check("conflicts_after4", 64'(conflicts), 64'd5);
        check("conflicts_w2_sat", 64'(c2_conflicts), 64'd3);
        set_p0(1'b0, 1'b0, 6'd0, 32'h0);
        set_p1(1'b0, 1'b0, 6'd0, 32'h0);
        step();

        // Write by port 0 contends with read by port 1; each held until granted
        set_p0(1'b1, 1'b1, 6'd3, 32'hA5A5_5A5A);
        set_p1(1'b1, 1'b0, 6'd5, 32'h0);
        for (int i = 0; i < 4 && (p0_req || p1_req); i++) begin
            step();
            if (e_g0) p0_req = 1'b0;
            if (e_g1) p1_req = 1'b0;
        end
        check("hold_retry_done", 64'({p0_req, p1_req}), 64'd0);
        set_p0(1'b1, 1'b0, 6'd3, 32'h0);
        step();
        set_p0(1'b0, 1'b0, 6'd0, 32'h0);
        step();
        check("p0_rdata_a5a5", 64'(p0_rdata), 64'h0000_0000_A5A5_5A5A);

        // Back-to-back reads by port 1
        set_p1(1'b1, 1'b0, 6'd9, 32'h0);
        step();
        set_p1(1'b1, 1'b0, 6'd5, 32'h0);
        step();
        set_p1(1'b0, 1'b0, 6'd0, 32'h0);
        step();

        // Reset rises the cycle after a port 1 read grant
        set_p1(1'b1, 1'b0, 6'd9, 32'h0);
        step();
        set_p1(1'b0, 1'b0, 6'd0, 32'h0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        set_p0(1'b1, 1'b0, 6'd5, 32'h0);
        set_p1(1'b1, 1'b0, 6'd9, 32'h0);
        step();
`ifdef MEM_ARB_RR_EN
        check("ptr_after_rst", 64'(obs_g1), 64'd0);
`else
        check("ptr_after_rst", 64'(obs_g1), 64'd1);
`endif
        set_p0(1'b0, 1'b0, 6'd0, 32'h0);
        set_p1(1'b0, 1'b0, 6'd0, 32'h0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port data RAM between the instruction-fetch requester (port 0) and the load/store requester (port 1) of the core. It grants at most one access per cycle, drives the RAM address, write-data and write-enable lines, and returns registered read data to the winning port one cycle later. It also counts contention cycles for performance debug.

## Interface
- DATA_WIDTH, 32, RAM word width
- ADDR_WIDTH, 6, RAM word-address width
- CNT_WIDTH, 16, width of the contention counter

- i_clk  in  1  clock; all state updates on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_p0_req / i_p1_req  in  1  access request, per port
- i_p0_we / i_p1_we  in  1  1 = write, 0 = read
- i_p0_addr / i_p1_addr  in  ADDR_WIDTH  word address
- i_p0_wdata / i_p1_wdata  in  DATA_WIDTH  write data
- o_p0_gnt / o_p1_gnt  out  1  combinational grant; access performed this cycle
- o_p0_rvalid / o_p1_rvalid  out  1  registered; read data valid this cycle
- o_p0_rdata / o_p1_rdata  out  DATA_WIDTH  registered read data
- o_ram_addr  out  ADDR_WIDTH  to RAM i_addr
- o_ram_data  out  DATA_WIDTH  to RAM i_data
- o_ram_we  out  1  to RAM i_we
- i_ram_data  in  DATA_WIDTH  from RAM o_data (combinational read)
- o_conflicts  out  CNT_WIDTH  saturating count of cycles with both requests high

## Operation
- Requester rule: hold req, we, addr and wdata stable until the cycle in which its gnt is high. It may drop req or present a new access the following cycle.
- Grant selection is combinational from the two req inputs and the state:
  - Only one req high: that port is granted.
  - Both high: the winner is chosen per Configuration.
  - Neither high: no grant.
- Granted cycle: o_ram_addr, o_ram_data and o_ram_we mirror the winning port's addr, wdata and we.
- No grant, or i_rst high: o_ram_addr = 0, o_ram_data = 0, o_ram_we = 0.
- Write: the RAM is written at the rising edge that ends the grant cycle. No rvalid is produced.
- Read: i_ram_data is captured into the winner's rdata register at the rising edge that ends the grant cycle. That port's rvalid is 1 for exactly the next cycle.
- The non-granted port's rdata register holds its value. rvalid is 0 in every cycle not following a read grant to that port.
- o_conflicts increments each cycle with both req high and i_rst low. It saturates at all-ones and does not wrap.
- Registered state: last-winner pointer, two rvalid flops, two rdata registers, conflict counter.

## Timing
- Grant latency is 0 cycles: gnt is high in the same cycle as req when that port wins.
- Read data latency is 1 cycle from grant.
- Throughput is one access per cycle. Back-to-back reads by the same port give rvalid high on consecutive cycles.
- Reset values: pointer = 1 (port 0 wins the first contention), rvalid = 0, rdata = 0, o_conflicts = 0.
- While i_rst is high:
  - Both gnt outputs are 0.
  - o_ram_we is 0.
- Reset mid-operation: a read granted in the cycle before i_rst rises still yields rvalid in the i_rst cycle. At the next edge rvalid is cleared.
- Simultaneous write by one port and read by the other: only the winner proceeds. The loser is retried on a later cycle with no data loss, since inputs are held.
- Address wrap: none; the full ADDR_WIDTH address is passed through unmodified.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On contention, the port not recorded in the pointer wins.
  - The pointer updates to the winner on every grant, including uncontended grants.
- MEM_ARB_RR_EN undefined: fixed priority. Port 1 (data) always wins contention; the pointer is not used.
- The counter, handshake and timing are identical in both builds.

## Test plan
- Reset: hold i_rst with both req high → gnt = 0, o_ram_we = 0, rvalid = 0, o_conflicts = 0.
- Port 0 reads addr 5 holding 0xDEADBEEF → o_p0_gnt = 1 in cycle N; o_p0_rvalid = 1 and o_p0_rdata = 0xDEADBEEF in N+1; o_p1_rvalid = 0.
- Port 1 writes 0x12345678 to addr 9, then port 0 reads addr 9 → port 0 gets 0x12345678 one cycle after its grant.
- Both ports request continuously for 4 cycles:
  - RR build: grants P0, P1, P0, P1.
  - Fixed build: grants P1 ×4.
  - Both builds: o_conflicts = 4.
- Preload o_conflicts near max with CNT_WIDTH = 2 and 5 contention cycles → counter stops at 3.
- Raise i_rst the cycle after a port 1 read grant → o_p1_rvalid = 1 during the reset cycle and 0 after; the pointer returns to 1.
